// File: rtl/params_pkg.sv
// ----------------------------------------------------------------------------
// params_pkg
// Shared panel geometry and the derived widths used by the frame-buffer
// read side. pixel_row_fetch takes its parameter defaults from here and
// uses the fetch_state_t enum for its row-walk FSM.
//
// Contents:
//   PIXEL_WIDTH, PIXEL_HEIGHT, PIXEL_HALFHEIGHT, BYTES_PER_PIXEL - geometry
//   WORD_W   - one frame-buffer word (both half-panel pixels)
//   ADDR_B_W - frame-buffer read-port address width
//   ROW_W    - scan-half row index width
//   COL_W    - column index width
//   fetch_state_t - IDLE / FETCH / DRAIN / DONE
// ----------------------------------------------------------------------------
package params_pkg;

  localparam int PIXEL_WIDTH      = 64;
  localparam int PIXEL_HEIGHT     = 32;
  localparam int PIXEL_HALFHEIGHT = 16;
  localparam int BYTES_PER_PIXEL  = 2;

  localparam int WORD_W   = (PIXEL_HEIGHT / PIXEL_HALFHEIGHT) * BYTES_PER_PIXEL * 8;
  localparam int ADDR_B_W = $clog2(PIXEL_HALFHEIGHT * PIXEL_WIDTH);
  localparam int ROW_W    = $clog2(PIXEL_HALFHEIGHT);
  localparam int COL_W    = $clog2(PIXEL_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage : params_pkg

// File: rtl/fetch_skid_fifo.sv
// ----------------------------------------------------------------------------
// fetch_skid_fifo
// Depth-2 register FIFO holding {col, word} pairs between the frame-buffer
// read port and the pixel stream. The head entry is presented directly so the
// stream outputs stay stable while the consumer stalls.
//
// Ports:
//   clk          in   clock
//   rst_n_i      in   synchronous active-low reset (clears entries and count)
//   push_i       in   write col_i/word_i at the end of this cycle
//   pop_i        in   drop the head entry at the end of this cycle
//   col_i        in   column tag of the pushed word
//   word_i       in   pushed data word
//   count_o      out  number of stored entries (0..2)
//   head_col_o   out  column tag of the head entry
//   head_word_o  out  data word of the head entry
//   empty_o      out  no entries stored
//   full_o       out  two entries stored
// ----------------------------------------------------------------------------
module fetch_skid_fifo #(
  parameter int WORD_W = 32,
  parameter int COL_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [1:0]        count_o,
  output logic [COL_W-1:0]  head_col_o,
  output logic [WORD_W-1:0] head_word_o,
  output logic              empty_o,
  output logic              full_o
);

  typedef struct packed {
    logic [COL_W-1:0]  col;
    logic [WORD_W-1:0] word;
  } entry_t;

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  logic do_push;
  logic do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; the upstream credit check keeps this from being needed.
  assign do_push = push_i && (!full_o || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst_n_i) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == 1'(gi))) begin
          mem_q[gi] <= '{col: col_i, word: word_i};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count_o     = count_q;
  assign head_col_o  = mem_q[rd_ptr_q].col;
  assign head_word_o = mem_q[rd_ptr_q].word;

endmodule : fetch_skid_fifo

// File: rtl/pixel_row_fetch.sv
// ----------------------------------------------------------------------------
// pixel_row_fetch
// Walks one display row of the multimem frame buffer (read port B) on a
// start pulse: one read per column, the one-cycle read latency absorbed by a
// depth-2 skid FIFO, and each column word presented on a valid/ready stream
// toward the panel shift/PWM stage.
//
// Build option:
//   PIXEL_ROW_FETCH_MIRROR_EN - when defined, columns are walked from
//   PIXEL_WIDTH-1 down to 0 (pixel_last on col 0); otherwise 0 up to
//   PIXEL_WIDTH-1 (pixel_last on the top column).
//
// Ports:
//   clk              in   clock (same as multimem ClockB)
//   reset            in   synchronous active-low reset; aborts a row
//   start            in   row request, sampled only in IDLE
//   row              in   row index, sampled with start
//   busy             out  high from the cycle after an accepted start through done
//   done             out  one-cycle pulse after the final beat is accepted
//   ram_b_address    out  multimem AddressB (holds between reads)
//   ram_b_clk_enable out  multimem ClockEnB, high in read-issue cycles only
//   ram_b_data       in   multimem QB, valid the cycle after an issue
//   pixel_data       out  column word
//   pixel_col        out  true column index of pixel_data
//   pixel_last       out  final beat of the row
//   pixel_valid      out  stream valid
//   pixel_ready      in   stream ready
// ----------------------------------------------------------------------------
module pixel_row_fetch #(
  parameter  int PIXEL_WIDTH      = params_pkg::PIXEL_WIDTH,
  parameter  int PIXEL_HEIGHT     = params_pkg::PIXEL_HEIGHT,
  parameter  int PIXEL_HALFHEIGHT = params_pkg::PIXEL_HALFHEIGHT,
  parameter  int BYTES_PER_PIXEL  = params_pkg::BYTES_PER_PIXEL,
  localparam int WORD_W   = (PIXEL_HEIGHT / PIXEL_HALFHEIGHT) * BYTES_PER_PIXEL * 8,
  localparam int ADDR_B_W = $clog2(PIXEL_HALFHEIGHT * PIXEL_WIDTH),
  localparam int ROW_W    = $clog2(PIXEL_HALFHEIGHT),
  localparam int COL_W    = $clog2(PIXEL_WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROW_W-1:0]    row,
  output logic                busy,
  output logic                done,
  output logic [ADDR_B_W-1:0] ram_b_address,
  output logic                ram_b_clk_enable,
  input  logic [WORD_W-1:0]   ram_b_data,
  output logic [WORD_W-1:0]   pixel_data,
  output logic [COL_W-1:0]    pixel_col,
  output logic                pixel_last,
  output logic                pixel_valid,
  input  logic                pixel_ready
);

  import params_pkg::fetch_state_t;
  import params_pkg::IDLE;
  import params_pkg::FETCH;
  import params_pkg::DRAIN;
  import params_pkg::DONE;

`ifdef PIXEL_ROW_FETCH_MIRROR_EN
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(PIXEL_WIDTH - 1);
  localparam logic [COL_W-1:0] LAST_COL  = '0;
`else
  localparam logic [COL_W-1:0] FIRST_COL = '0;
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(PIXEL_WIDTH - 1);
`endif

  fetch_state_t        state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                inflight_q;
  logic [COL_W-1:0]    inflight_col_q;
  logic [ADDR_B_W-1:0] addr_hold_q;

  logic [1:0]          fifo_count;
  logic [1:0]          fifo_count_next;
  logic [2:0]          occupancy;
  logic                fifo_empty;
  logic                fifo_full;
  logic [COL_W-1:0]    head_col;
  logic [WORD_W-1:0]   head_word;

  logic                pop;
  logic                credit_ok;
  logic                issue;
  logic [ADDR_B_W-1:0] addr_cur;

  // Stream handshake and read credit. The word returning this cycle is
  // counted through inflight_q, so FIFO entries plus the outstanding read
  // never exceed the two FIFO slots.
  assign pop             = pixel_valid && pixel_ready;
  assign occupancy       = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign credit_ok       = (occupancy < 3'd2);
  assign fifo_count_next = fifo_count + {1'b0, inflight_q} - {1'b0, pop};

  assign addr_cur = ADDR_B_W'(row_q) * ADDR_B_W'(PIXEL_WIDTH) + ADDR_B_W'(col_q);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    issue   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && (32'(row) < PIXEL_HALFHEIGHT)) begin
          row_d   = row;
          col_d   = FIRST_COL;
          state_d = FETCH;
        end
      end
      FETCH: begin
        issue = credit_ok;
        if (credit_ok) begin
`ifdef PIXEL_ROW_FETCH_MIRROR_EN
          col_d = col_q - COL_W'(1);
`else
          col_d = col_q + COL_W'(1);
`endif
          if (col_q == LAST_COL) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Look at the post-edge FIFO count so done lands exactly one cycle
        // after the final handshake.
        if (fifo_count_next == 2'd0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_col_q <= '0;
      addr_hold_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_col_q <= col_q;
        addr_hold_q    <= addr_cur;
      end
    end
  end

  // The returning word is captured together with the column it was read for.
  fetch_skid_fifo #(
    .WORD_W (WORD_W),
    .COL_W  (COL_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n_i     (reset),
    .push_i      (inflight_q),
    .pop_i       (pop),
    .col_i       (inflight_col_q),
    .word_i      (ram_b_data),
    .count_o     (fifo_count),
    .head_col_o  (head_col),
    .head_word_o (head_word),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign ram_b_clk_enable = issue;
  assign ram_b_address    = issue ? addr_cur : addr_hold_q;

  assign pixel_valid = !fifo_empty;
  assign pixel_data  = head_word;
  assign pixel_col   = head_col;
  // Gated by valid so the cleared head (col 0) never reads as a last beat.
  assign pixel_last  = pixel_valid && (head_col == LAST_COL);

endmodule : pixel_row_fetch

// File: tb/tb_pixel_row_fetch.sv
// ----------------------------------------------------------------------------
// tb_pixel_row_fetch
// Directed bench for pixel_row_fetch with a 64x32 panel, 16-row halves and
// 2 bytes per pixel. A behavioral multimem port B (one-cycle registered read)
// holds word[a] = {22'h0, a}. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pixel_row_fetch;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  row;
  logic        busy;
  logic        done;
  logic [9:0]  ram_b_address;
  logic        ram_b_clk_enable;
  logic [31:0] ram_b_data = '0;
  logic [31:0] pixel_data;
  logic [5:0]  pixel_col;
  logic        pixel_last;
  logic        pixel_valid;
  logic        pixel_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = {22'h0, a[9:0]};
  end

  always @(posedge clk) begin
    if (ram_b_clk_enable) ram_b_data <= mem[ram_b_address];
  end

  pixel_row_fetch #(
    .PIXEL_WIDTH      (64),
    .PIXEL_HEIGHT     (32),
    .PIXEL_HALFHEIGHT (16),
    .BYTES_PER_PIXEL  (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .row              (row),
    .busy             (busy),
    .done             (done),
    .ram_b_address    (ram_b_address),
    .ram_b_clk_enable (ram_b_clk_enable),
    .ram_b_data       (ram_b_data),
    .pixel_data       (pixel_data),
    .pixel_col        (pixel_col),
    .pixel_last       (pixel_last),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected column for the n-th issue / beat of a row.
  function automatic int exp_col(input int n);
`ifdef PIXEL_ROW_FETCH_MIRROR_EN
    return W - 1 - n;
`else
    return n;
`endif
  endfunction

  // Runs one row request and checks issue addresses, beats, stalls, credit
  // and done timing. abort_col >= 0 applies reset at that column's handshake.
  task automatic run_row(input int r, input bit bp, input int abort_col,
                         input bit ign_busy, input bit ign_done);
    logic [3:0]  pat = 4'b1001;   // ready pattern 1,0,0,1 by cycle index
    int          n_iss = 0, n_beat = 0;
    int          first_iss = -1, first_valid = -1, last_hs = -1;
    int          busy_cnt = 0;
    bit          got_done = 0, aborting = 0, prev_stall = 0;
    logic [31:0] held_data = '0;
    logic [5:0]  held_col = '0;
    logic        held_last = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; row = 4'(r); pixel_ready = 1'b1;
    @(negedge clk);
    $display("start row=%0d bp=%0d abort_col=%0d", r, bp, abort_col);

    for (int cyc = 1; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; row = 4'(r);
      if (ign_busy && cyc == 10) begin start = 1'b1; row = 4'd5; end
      if (ign_done && done)      begin start = 1'b1; row = 4'd7; end
      pixel_ready = bp ? pat[cyc % 4] : 1'b1;
      #1;
      if (abort_col >= 0 && pixel_valid && pixel_ready && int'(pixel_col) == abort_col) begin
        aborting = 1;
        reset    = 1'b0;
      end
      @(negedge clk);
      busy_cnt += int'(busy);
      if (ram_b_clk_enable) begin
        if (first_iss < 0) first_iss = cyc;
        chk("issue_addr", 32'(ram_b_address), 32'(r * W + exp_col(n_iss)));
        n_iss++;
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(pixel_valid), 32'd1);
        chk("hold_data",  pixel_data,       held_data);
        chk("hold_col",   32'(pixel_col),   32'(held_col));
        chk("hold_last",  32'(pixel_last),  32'(held_last));
      end
      if (pixel_valid && pixel_ready) begin
        if (first_valid < 0) first_valid = cyc;
        chk("beat_data", pixel_data,      32'(r * W + exp_col(n_beat)));
        chk("beat_col",  32'(pixel_col),  32'(exp_col(n_beat)));
        chk("beat_last", 32'(pixel_last), 32'(n_beat == W - 1));
        $display("beat row=%0d col=%0d data=%0h last=%0d cyc=%0d",
                 r, pixel_col, pixel_data, pixel_last, cyc);
        n_beat++;
        last_hs = cyc;
      end
      chk("credit_le_2", 32'((n_iss - n_beat) <= 2), 32'd1);
      prev_stall = pixel_valid && !pixel_ready;
      held_data  = pixel_data;
      held_col   = pixel_col;
      held_last  = pixel_last;
      if (aborting) break;
      if (done) begin
        got_done = 1;
        chk("done_beats", 32'(n_beat), 32'(W));
        chk("done_after_last", 32'(cyc), 32'(last_hs + 1));
        if (!bp) chk("busy_cycles", 32'(busy_cnt), 32'(W + 3));
        $display("done row=%0d cyc=%0d busy_cycles=%0d", r, cyc, busy_cnt);
        break;
      end
    end

    chk("first_issue_cyc", 32'(first_iss),   32'd1);
    chk("first_valid_cyc", 32'(first_valid), 32'd3);

    if (aborting) begin
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("abort_valid", 32'(pixel_valid), 32'd0);
      chk("abort_busy",  32'(busy),        32'd0);
      chk("abort_done",  32'(done),        32'd0);
      $display("abort row=%0d after %0d beats", r, n_beat);
    end else begin
      chk("done_seen", 32'(got_done), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; row = 4'd3; pixel_ready = 1'b0;

    // Reset held for two edges with start asserted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy",  32'(busy),             32'd0);
      chk("rst_done",  32'(done),             32'd0);
      chk("rst_en",    32'(ram_b_clk_enable), 32'd0);
      chk("rst_addr",  32'(ram_b_address),    32'd0);
      chk("rst_valid", 32'(pixel_valid),      32'd0);
      chk("rst_data",  pixel_data,            32'd0);
      chk("rst_col",   32'(pixel_col),        32'd0);
      chk("rst_last",  32'(pixel_last),       32'd0);
      $display("reset cycle %0d busy=%0d valid=%0d", i, busy, pixel_valid);
    end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Row 3, full throughput, start row=5 mid-row and start row=7 in the
    // done cycle both ignored.
    run_row(3, 1'b0, -1, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    chk("post_done_valid", 32'(pixel_valid), 32'd0);

    // Row 0 under ready pattern 1,0,0,1.
    run_row(0, 1'b1, -1, 1'b0, 1'b0);

    // Row 0 aborted by reset at the column-20 handshake, then restarted.
    run_row(0, 1'b0, 20, 1'b0, 1'b0);
    run_row(0, 1'b0, -1, 1'b0, 1'b0);

    // With 16 rows the 4-bit row port cannot encode an out-of-range index,
    // so the row-range rejection has no reachable stimulus here.

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pixel_row_fetch
